bc_stage_if_prefetch: RTL and testbench
=======================================

# bc_stage_if_prefetch

Parametrised instruction-fetch stage with a prefetch buffer, successor to the single-beat fetch stage. Keeps up to FIFO_DEPTH requests in flight against the instruction memory, buffers returned words with their PCs, and presents them to decode through a valid/ready handshake. A redirect (branch, exception, pipeline reset) flushes the buffer, discards stale in-flight responses, and restarts fetch at a new PC. Sits between the instruction-memory port and the decode stage.

## Interface
- ADDR_WIDTH, 32, PC and memory address width
- INSTR_WIDTH, 32, instruction word width
- FIFO_DEPTH, 4, prefetch buffer entries; power of two, ≥2; also the maximum number of outstanding requests
- PC_STEP, 1, PC increment per instruction (1 = word addressing, as in the current memory model)
- RESET_PC, 0, fetch address after reset

Ports:
- i_clk  in  1  clock; all logic on the rising edge
- i_rst  in  1  synchronous, active-high reset
- i_redirect  in  1  flush and restart fetch
- i_redirect_pc  in  ADDR_WIDTH  new fetch PC, sampled when i_redirect=1
- o_imem_req  out  1  read request valid
- o_imem_addr  out  ADDR_WIDTH  read address
- i_imem_gnt  in  1  memory accepts the request this cycle
- i_imem_rvalid  in  1  read data valid; responses return in request order
- i_imem_rdata  in  INSTR_WIDTH  read data
- o_instr_valid  out  1  buffer head valid
- o_instr  out  INSTR_WIDTH  instruction at buffer head
- o_instr_pc  out  ADDR_WIDTH  PC of o_instr
- i_instr_ready  in  1  decode consumes the head when o_instr_valid=1

## Operation
- State:
  - fetch_pc: next address to request
  - resp_pc: PC of the next non-dropped response
  - outstanding: granted requests whose responses have not yet returned
  - drop_cnt: responses still to be discarded
  - FIFO of {pc, instr}
  - Counter widths: $clog2(FIFO_DEPTH)+1.
- Request rule:
  - o_imem_req = !i_rst && !i_redirect && (outstanding + fifo_count < FIFO_DEPTH).
  - o_imem_addr = fetch_pc.
  - On req && gnt: fetch_pc += PC_STEP; outstanding++.
  - Addresses wrap modulo 2^ADDR_WIDTH.
- Response rule:
  - On rvalid: outstanding--.
  - If drop_cnt>0: drop_cnt-- and the word is discarded.
  - Otherwise push {resp_pc, rdata} and resp_pc += PC_STEP.
  - The credit rule guarantees the FIFO never overflows. A push into a full FIFO is an assertion failure.
- Pop: o_instr_valid && i_instr_ready.
  - Pop and push may occur in the same cycle, including when the FIFO is full or empty.
- Redirect (priority over push and pop):
  - FIFO cleared.
  - fetch_pc and resp_pc set to i_redirect_pc.
  - drop_cnt set to outstanding after this cycle's rvalid and gnt are accounted for.
  - Any response arriving in the redirect cycle is discarded. A request granted in that cycle cannot occur, because req=0 during redirect.
- Reset, including mid-operation:
  - fetch_pc and resp_pc = RESET_PC; outstanding, drop_cnt and FIFO cleared.
  - Responses from the memory to pre-reset requests are the memory's responsibility: the memory is reset with the same i_rst.

## Timing
- Outputs in reset: o_imem_req=0, o_instr_valid=0; o_instr, o_instr_pc = 0.
- First request: o_imem_req=1, address RESET_PC, in the first cycle after i_rst deasserts.
- Response latency: rvalid in cycle N gives o_instr_valid=1 in cycle N+1. FIFO output is registered; there is no bypass.
- Throughput: one instruction per cycle with a 1-cycle memory and continuous ready, given FIFO_DEPTH≥2.
- Redirect asserted in cycle N:
  - o_imem_req=0 in cycle N.
  - o_instr_valid=0 in cycle N+1.
  - Request for i_redirect_pc in cycle N+1.
  - First valid instruction no earlier than N+3 with a 1-cycle memory.
- Back-to-back redirects: the last one wins. drop_cnt accumulates correctly because it is recomputed from outstanding each time.
- Stall (ready=0): the FIFO fills, then o_imem_req falls once outstanding + count = FIFO_DEPTH. Requests resume in the cycle after a pop frees credit.

## Structure
- Package bc_if_pkg holds:
  - RESET_PC_DEFAULT and PC_STEP_DEFAULT constants
  - a count-width function, $clog2(depth)+1
- Sub-module bc_sync_fifo (parametrised WIDTH and DEPTH):
  - ports: push, pop, flush, full, empty, count
  - instantiated with WIDTH = ADDR_WIDTH + INSTR_WIDTH
- The credit and drop counters live in the top-level module.

## Test plan
- Reset, then a 1-cycle memory preloaded with 0x114, 0x214, 0xAAAAAAAA at addresses 0–2, with ready=1 → instructions delivered in order at pc 0,1,2 on consecutive cycles; first o_instr_valid 2 cycles after reset release.
- ready held 0 for 10 cycles, FIFO_DEPTH=4 → o_imem_req drops after 4 grants; exactly 4 entries buffered; no words lost after ready returns.
- Memory with 3-cycle latency, 2 requests outstanding, redirect to 0x40 → both stale responses dropped; next instruction has pc 0x40 and data mem[0x40].
- Redirect in the same cycle as rvalid and as a pop → the response is dropped and the pop is ignored; the FIFO is empty the next cycle.
- i_rst asserted mid-stream with the FIFO half full → o_instr_valid=0 the next cycle; fetch restarts at RESET_PC.
- fetch_pc starting at 0xFFFFFFFF, PC_STEP=1 → the next request address is 0x00000000.

Source files
------------

// File: rtl/bc_if_pkg.sv
// Shared constants and helpers for the prefetching fetch stage.
// Imported by the stage top and its buffer.
package bc_if_pkg;

  localparam int unsigned RESET_PC_DEFAULT = 0;
  localparam int unsigned PC_STEP_DEFAULT  = 1;

  // Counters must hold the value DEPTH itself, not just DEPTH-1.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bc_sync_fifo.sv
// Synchronous FIFO with registered storage and no bypass path.
// Flush empties it and wins over push and pop.
module bc_sync_fifo
  import bc_if_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        flush,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rdata,
  output logic                        full,
  output logic                        empty,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/bc_stage_if_prefetch.sv
// Instruction fetch stage with a credit-limited prefetch buffer.
// Redirects flush the buffer and drop stale in-flight responses.
module bc_stage_if_prefetch
  import bc_if_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int PC_STEP     = PC_STEP_DEFAULT,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC =
    ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_redirect,
  input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
  output logic                   o_imem_req,
  output logic [ADDR_WIDTH-1:0]  o_imem_addr,
  input  logic                   i_imem_gnt,
  input  logic                   i_imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
  output logic                   o_instr_valid,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0]  o_instr_pc,
  input  logic                   i_instr_ready
);

  localparam int CW = cnt_width(FIFO_DEPTH);
  localparam int FW = ADDR_WIDTH + INSTR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] resp_pc;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         outstanding_nxt;
  logic [CW-1:0]         drop_cnt;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           inflight;
  logic                  fire;
  logic                  dropping;
  logic                  push;
  logic                  pop;
  logic                  flush;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  head_valid;
  logic [FW-1:0]         head;

  // Credits cover both buffered words and words still in flight.
  assign inflight   = {1'b0, outstanding} + {1'b0, fifo_count};
  assign o_imem_req = !i_rst && !i_redirect &&
                      (inflight < (CW+1)'(FIFO_DEPTH));
  assign o_imem_addr = fetch_pc;

  assign fire     = o_imem_req && i_imem_gnt;
  assign dropping = (drop_cnt != '0);
  assign push     = i_imem_rvalid && !dropping && !i_redirect;
  assign pop      = head_valid && i_instr_ready && !i_redirect;
  assign flush    = i_rst || i_redirect;

  assign outstanding_nxt = outstanding + CW'(fire)
                         - CW'(i_imem_rvalid);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (i_redirect) begin
        fetch_pc <= i_redirect_pc;
        resp_pc  <= i_redirect_pc;
        drop_cnt <= outstanding_nxt;
      end else begin
        if (fire) fetch_pc <= fetch_pc + STEP;
        if (push) resp_pc  <= resp_pc + STEP;
        if (i_imem_rvalid && dropping)
          drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  bc_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({resp_pc, i_imem_rdata}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head_valid    = !fifo_empty && !i_rst;
  assign o_instr_valid = head_valid;
  assign o_instr       = head_valid ? head[INSTR_WIDTH-1:0] : '0;
  assign o_instr_pc    = head_valid ? head[FW-1:INSTR_WIDTH] : '0;

  a_no_overflow: assert property (
    @(posedge i_clk) disable iff (flush)
    !(push && fifo_full && !pop)
  );

endmodule

// File: tb/tb_bc_stage_if_prefetch.sv
// Bench for the prefetching fetch stage: latency-configurable memory
// model plus an in-order scoreboard of delivered instructions.
module tb_bc_stage_if_prefetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic        clk = 0;
  logic        i_rst = 1;
  logic        i_redirect = 0;
  logic [31:0] i_redirect_pc = 0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        i_instr_ready = 0;

  int checks = 0;
  int passes = 0;
  int fires = 0;
  int gnt_limit = 0;
  int lat = 1;

  exp_t sb[$];

  always #5 clk = ~clk;

  bc_stage_if_prefetch dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_instr_valid (o_instr_valid),
    .o_instr       (o_instr),
    .o_instr_pc    (o_instr_pc),
    .i_instr_ready (i_instr_ready)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h0000_0114;
      32'd1:   return 32'h0000_0214;
      32'd2:   return 32'hAAAA_AAAA;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  // Memory: grants limited by gnt_limit, fixed latency lat.
  logic        fire_s = 0;
  logic        rst_s = 1;
  logic [31:0] addr_s = 0;
  logic        pv [8];
  logic [31:0] pd [8];

  assign i_imem_gnt    = (fires < gnt_limit);
  assign i_imem_rvalid = pv[0];
  assign i_imem_rdata  = pd[0];

  always @(negedge clk) begin
    fire_s = o_imem_req && i_imem_gnt;
    addr_s = o_imem_addr;
    rst_s  = i_rst;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 7; i++) begin
      pv[i] <= pv[i+1];
      pd[i] <= pd[i+1];
    end
    pv[7] <= 1'b0;
    pd[7] <= 32'h0;
    if (rst_s) begin
      for (int i = 0; i < 8; i++) pv[i] <= 1'b0;
    end else if (fire_s) begin
      pv[lat-1] <= 1'b1;
      pd[lat-1] <= word(addr_s);
      fires <= fires + 1;
    end
  end

  // Scoreboard: every consumed instruction must match the next expected.
  exp_t got_e;
  always @(negedge clk) begin
    if (!i_rst && !i_redirect && o_instr_valid && i_instr_ready) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_extra pc=%h instr=%h required none",
                 o_instr_pc, o_instr);
      end else begin
        got_e = sb.pop_front();
        if (o_instr_pc !== got_e.pc || o_instr !== got_e.ins)
          $display("FAIL sb_data pc=%h instr=%h required pc=%h instr=%h",
                   o_instr_pc, o_instr, got_e.pc, got_e.ins);
        else
          passes++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1;
    i_redirect = 0;
    sb.delete();
    step();
    step();
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    sb.push_back('{pc: pc, ins: word(pc)});
  endtask

  task automatic wait_empty(input int maxc);
    for (int n = 0; n < maxc && sb.size() != 0; n++) step();
  endtask

  task automatic test_reset();
    i_rst = 1;
    i_instr_ready = 0;
    gnt_limit = fires;
    step();
    step();
    @(negedge clk);
    checks++;
    if (o_imem_req !== 1'b0)
      $display("FAIL rst_req got=%b required=0", o_imem_req);
    else passes++;
    checks++;
    if (o_instr_valid !== 1'b0)
      $display("FAIL rst_valid got=%b required=0", o_instr_valid);
    else passes++;
    checks++;
    if (o_instr !== 32'h0)
      $display("FAIL rst_instr got=%h required=0", o_instr);
    else passes++;
    checks++;
    if (o_instr_pc !== 32'h0)
      $display("FAIL rst_pc got=%h required=0", o_instr_pc);
    else passes++;
    step();
    i_rst = 0;
    @(negedge clk);
    checks++;
    if (o_imem_req !== 1'b1)
      $display("FAIL first_req got=%b required=1", o_imem_req);
    else passes++;
    checks++;
    if (o_imem_addr !== 32'h0)
      $display("FAIL first_addr got=%h required=0", o_imem_addr);
    else passes++;
  endtask

  task automatic test_basic();
    logic [5:0] seen;
    do_reset();
    lat = 1;
    i_instr_ready = 1;
    gnt_limit = fires + 3;
    sb.push_back('{pc: 32'd0, ins: 32'h0000_0114});
    sb.push_back('{pc: 32'd1, ins: 32'h0000_0214});
    sb.push_back('{pc: 32'd2, ins: 32'hAAAA_AAAA});
    step();
    i_rst = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      seen[c] = o_instr_valid;
      step();
    end
    checks++;
    if (seen !== 6'b011100)
      $display("FAIL basic_timing got=%b required=011100", seen);
    else passes++;
    wait_empty(20);
    checks++;
    if (sb.size() != 0)
      $display("FAIL basic_drain left=%0d required=0", sb.size());
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [11:0] seen;
    do_reset();
    lat = 1;
    i_instr_ready = 1;
    gnt_limit = fires + 8;
    for (int i = 0; i < 8; i++) expect_pc(32'(i));
    step();
    i_rst = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      seen[c] = o_instr_valid;
      step();
    end
    checks++;
    if (seen !== 12'h3FC)
      $display("FAIL b2b_valid got=%h required=3fc", seen);
    else passes++;
    checks++;
    if (sb.size() != 0)
      $display("FAIL b2b_drain left=%0d required=0", sb.size());
    else passes++;
  endtask

  task automatic test_stall();
    int f0;
    do_reset();
    lat = 1;
    i_instr_ready = 0;
    gnt_limit = fires + 6;
    for (int i = 0; i < 6; i++) expect_pc(32'(i));
    step();
    i_rst = 0;
    f0 = fires;
    repeat (9) step();
    @(negedge clk);
    checks++;
    if (fires - f0 != 4)
      $display("FAIL stall_grants got=%0d required=4", fires - f0);
    else passes++;
    checks++;
    if (o_imem_req !== 1'b0)
      $display("FAIL stall_req got=%b required=0", o_imem_req);
    else passes++;
    step();
    i_instr_ready = 1;
    @(negedge clk);
    checks++;
    if (o_imem_req !== 1'b0 || o_instr_valid !== 1'b1)
      $display("FAIL stall_full req=%b valid=%b required req=0 valid=1",
               o_imem_req, o_instr_valid);
    else passes++;
    step();
    @(negedge clk);
    checks++;
    if (o_imem_req !== 1'b1)
      $display("FAIL stall_resume got=%b required=1", o_imem_req);
    else passes++;
    wait_empty(40);
    checks++;
    if (sb.size() != 0)
      $display("FAIL stall_drain left=%0d required=0", sb.size());
    else passes++;
  endtask

  task automatic test_redirect_drop();
    logic [4:0] seen;
    do_reset();
    lat = 3;
    i_instr_ready = 1;
    gnt_limit = fires + 2;
    step();
    i_rst = 0;
    step();
    step();
    i_redirect = 1;
    i_redirect_pc = 32'h40;
    @(negedge clk);
    checks++;
    if (o_imem_req !== 1'b0)
      $display("FAIL redir_req got=%b required=0", o_imem_req);
    else passes++;
    step();
    i_redirect = 0;
    gnt_limit = fires + 2;
    expect_pc(32'h40);
    expect_pc(32'h41);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h40)
          $display("FAIL redir_addr req=%b addr=%h required req=1 addr=40",
                   o_imem_req, o_imem_addr);
        else passes++;
      end
      seen[c] = o_instr_valid;
      step();
    end
    checks++;
    if (seen !== 5'b10000)
      $display("FAIL redir_valid got=%b required=10000", seen);
    else passes++;
    wait_empty(40);
    checks++;
    if (sb.size() != 0)
      $display("FAIL redir_drain left=%0d required=0", sb.size());
    else passes++;
  endtask

  task automatic test_redirect_collide();
    logic [1:0] seen;
    do_reset();
    lat = 1;
    i_instr_ready = 1;
    gnt_limit = fires + 2;
    step();
    i_rst = 0;
    step();
    step();
    i_redirect = 1;
    i_redirect_pc = 32'h80;
    @(negedge clk);
    checks++;
    if (o_instr_valid !== 1'b1 || o_instr_pc !== 32'h0)
      $display("FAIL coll_setup valid=%b pc=%h required valid=1 pc=0",
               o_instr_valid, o_instr_pc);
    else passes++;
    step();
    i_redirect = 0;
    gnt_limit = fires + 1;
    expect_pc(32'h80);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      seen[c] = o_instr_valid;
      step();
    end
    checks++;
    if (seen !== 2'b00)
      $display("FAIL coll_empty got=%b required=00", seen);
    else passes++;
    wait_empty(20);
    checks++;
    if (sb.size() != 0)
      $display("FAIL coll_drain left=%0d required=0", sb.size());
    else passes++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    lat = 1;
    i_instr_ready = 0;
    gnt_limit = fires + 2;
    step();
    i_rst = 0;
    repeat (5) step();
    @(negedge clk);
    checks++;
    if (o_instr_valid !== 1'b1)
      $display("FAIL mid_setup got=%b required=1", o_instr_valid);
    else passes++;
    step();
    i_rst = 1;
    step();
    i_rst = 0;
    i_instr_ready = 1;
    gnt_limit = fires + 1;
    expect_pc(32'h0);
    @(negedge clk);
    checks++;
    if (o_instr_valid !== 1'b0)
      $display("FAIL mid_valid got=%b required=0", o_instr_valid);
    else passes++;
    checks++;
    if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0)
      $display("FAIL mid_restart req=%b addr=%h required req=1 addr=0",
               o_imem_req, o_imem_addr);
    else passes++;
    wait_empty(20);
    checks++;
    if (sb.size() != 0)
      $display("FAIL mid_drain left=%0d required=0", sb.size());
    else passes++;
  endtask

  task automatic test_wrap();
    do_reset();
    lat = 1;
    i_instr_ready = 1;
    gnt_limit = fires;
    step();
    i_rst = 0;
    step();
    i_redirect = 1;
    i_redirect_pc = 32'hFFFF_FFFF;
    step();
    i_redirect = 0;
    gnt_limit = fires + 2;
    expect_pc(32'hFFFF_FFFF);
    expect_pc(32'h0);
    @(negedge clk);
    checks++;
    if (o_imem_addr !== 32'hFFFF_FFFF)
      $display("FAIL wrap_first got=%h required=ffffffff", o_imem_addr);
    else passes++;
    step();
    @(negedge clk);
    checks++;
    if (o_imem_addr !== 32'h0)
      $display("FAIL wrap_next got=%h required=00000000", o_imem_addr);
    else passes++;
    wait_empty(20);
    checks++;
    if (sb.size() != 0)
      $display("FAIL wrap_drain left=%0d required=0", sb.size());
    else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_redirect_drop();
    test_redirect_collide();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
